secret_accum_bank: RTL and testbench



---
 rtl/secret_accum_bank_if.sv | 30 +++
 rtl/secret_accum_bank.sv | 98 +++++++++
 tb/tb_secret_accum_bank.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/secret_accum_bank_if.sv
// Bus bundle for secret_accum_bank: per-channel accumulator controls and data,
// plus the opaque passthrough lane.
interface secret_accum_bank_if #(
  parameter int CHANNELS   = 2,
  parameter int WIDTH      = 32,
  parameter int PASS_WIDTH = 129
);

  logic [CHANNELS*WIDTH-1:0] accum_in;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       clear;
  logic [CHANNELS-1:0]       accum_bypass;
  logic [CHANNELS*WIDTH-1:0] accum_out;
  logic [CHANNELS*WIDTH-1:0] accum_bypass_out;
  logic [CHANNELS-1:0]       out_valid;
  logic [CHANNELS-1:0]       overflow;
  logic [PASS_WIDTH-1:0]     pass_in;
  logic [PASS_WIDTH-1:0]     pass_out;

  modport master (
    output accum_in, in_valid, clear, accum_bypass, pass_in,
    input  accum_out, accum_bypass_out, out_valid, overflow, pass_out
  );

  modport slave (
    input  accum_in, in_valid, clear, accum_bypass, pass_in,
    output accum_out, accum_bypass_out, out_valid, overflow, pass_out
  );

endinterface

// File: rtl/secret_accum_bank.sv
// Bank of independent registered accumulators with bypass, wrap/saturate
// overflow handling and sticky flags, plus a fixed-latency passthrough lane.
module secret_accum_bank #(
  parameter int CHANNELS   = 2,
  parameter int WIDTH      = 32,
  parameter int SATURATE   = 0,
  parameter int PASS_WIDTH = 129,
  parameter int PASS_DEPTH = 1
) (
  input logic              clk,
  input logic              rst_n,
  secret_accum_bank_if.slave bus
);

  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $error("secret_accum_bank: CHANNELS must be 1..16");
  end
  if (WIDTH < 1 || WIDTH > 128) begin : g_bad_width
    $error("secret_accum_bank: WIDTH must be 1..128");
  end
  if (SATURATE != 0 && SATURATE != 1) begin : g_bad_saturate
    $error("secret_accum_bank: SATURATE must be 0 or 1");
  end
  if (PASS_WIDTH < 1 || PASS_WIDTH > 1024) begin : g_bad_pass_width
    $error("secret_accum_bank: PASS_WIDTH must be 1..1024");
  end
  if (PASS_DEPTH < 1 || PASS_DEPTH > 16) begin : g_bad_pass_depth
    $error("secret_accum_bank: PASS_DEPTH must be 1..16");
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [WIDTH-1:0] add_val;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] byp_q, byp_d;
    logic             ov_q, ov_d;
    logic             val_q, val_d;

    assign add_val = bus.accum_in[c*WIDTH +: WIDTH];
    // The extra carry bit is the unsigned overflow indicator.
    assign sum = {1'b0, acc_q} + {1'b0, add_val};

    always_comb begin
      acc_d = acc_q;
      ov_d  = ov_q;
      val_d = 1'b0;
      byp_d = bus.accum_bypass[c] ? add_val : acc_q;
      if (bus.clear[c]) begin
        acc_d = '0;
        ov_d  = 1'b0;
        byp_d = '0;
      end else if (bus.in_valid[c]) begin
        if (sum[WIDTH]) begin
          ov_d  = 1'b1;
          acc_d = (SATURATE != 0) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
        end else begin
          acc_d = sum[WIDTH-1:0];
        end
        val_d = 1'b1;
        byp_d = bus.accum_bypass[c] ? add_val : acc_d;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q <= '0;
        byp_q <= '0;
        ov_q  <= 1'b0;
        val_q <= 1'b0;
      end else begin
        acc_q <= acc_d;
        byp_q <= byp_d;
        ov_q  <= ov_d;
        val_q <= val_d;
      end
    end

    assign bus.accum_out[c*WIDTH +: WIDTH]        = acc_q;
    assign bus.accum_bypass_out[c*WIDTH +: WIDTH] = byp_q;
    assign bus.overflow[c]                        = ov_q;
    assign bus.out_valid[c]                       = val_q;
  end

  logic [PASS_WIDTH-1:0] pass_q [PASS_DEPTH];

  // Free-running delay line; no enable so latency is always exactly PASS_DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PASS_DEPTH; i++) pass_q[i] <= '0;
    end else begin
      pass_q[0] <= bus.pass_in;
      for (int i = 1; i < PASS_DEPTH; i++) pass_q[i] <= pass_q[i-1];
    end
  end

  assign bus.pass_out = pass_q[PASS_DEPTH-1];

endmodule

// File: tb/tb_secret_accum_bank.sv
// Drives a wrap-mode and a saturate-mode bank with identical stimulus; expected
// responses are queued per edge and checked by an independent monitor.
module tb_secret_accum_bank;

  localparam int CH = 4;
  localparam int W  = 8;
  localparam int PW = 129;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   vec_num = 0;
  event check_ev;

  always #5 clk = ~clk;

  secret_accum_bank_if #(.CHANNELS(CH), .WIDTH(W), .PASS_WIDTH(PW)) bus0 ();
  secret_accum_bank_if #(.CHANNELS(CH), .WIDTH(W), .PASS_WIDTH(PW)) bus1 ();

  secret_accum_bank #(
    .CHANNELS(CH), .WIDTH(W), .SATURATE(0), .PASS_WIDTH(PW), .PASS_DEPTH(3)
  ) u_wrap (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  secret_accum_bank #(
    .CHANNELS(CH), .WIDTH(W), .SATURATE(1), .PASS_WIDTH(PW), .PASS_DEPTH(1)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  typedef struct {
    int                      vec;
    logic [1:0][CH*W-1:0]    acc;
    logic [1:0][CH*W-1:0]    byp;
    logic [1:0][CH-1:0]      ov;
    logic [1:0][CH-1:0]      val;
    logic [1:0][PW-1:0]      pass;
    logic                    hand;
    int                      ch;
    logic [1:0][W-1:0]       hacc;
    logic [1:0]              hov;
  } exp_t;

  exp_t sb[$];

  // Reference state: index 0 is the wrap bank, index 1 the saturate bank.
  logic [W-1:0]  m_acc [2][CH];
  logic [W-1:0]  m_byp [2][CH];
  logic          m_ov  [2][CH];
  logic          m_val [2][CH];
  logic [PW-1:0] m_pipe0 [3];
  logic [PW-1:0] m_pipe1;
  logic [PW-1:0] cur_pass;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < CH; c++) begin
        m_acc[i][c] = '0;
        m_byp[i][c] = '0;
        m_ov[i][c]  = 1'b0;
        m_val[i][c] = 1'b0;
      end
    end
    for (int s = 0; s < 3; s++) m_pipe0[s] = '0;
    m_pipe1 = '0;
  endtask

  task automatic model_step(input logic [CH-1:0] v, input logic [CH-1:0] cl,
                            input logic [CH-1:0] bp, input logic [CH*W-1:0] ain,
                            input logic [PW-1:0] pin);
    logic [W:0]   sum;
    logic [W-1:0] a;
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < CH; c++) begin
        a = ain[c*W +: W];
        if (cl[c]) begin
          m_acc[i][c] = '0;
          m_ov[i][c]  = 1'b0;
          m_val[i][c] = 1'b0;
          m_byp[i][c] = '0;
        end else if (v[c]) begin
          sum = {1'b0, m_acc[i][c]} + {1'b0, a};
          if (sum[W]) begin
            m_ov[i][c]  = 1'b1;
            m_acc[i][c] = (i == 1) ? {W{1'b1}} : sum[W-1:0];
          end else begin
            m_acc[i][c] = sum[W-1:0];
          end
          m_val[i][c] = 1'b1;
          m_byp[i][c] = bp[c] ? a : m_acc[i][c];
        end else begin
          m_val[i][c] = 1'b0;
          m_byp[i][c] = bp[c] ? a : m_acc[i][c];
        end
      end
    end
    m_pipe0[2] = m_pipe0[1];
    m_pipe0[1] = m_pipe0[0];
    m_pipe0[0] = pin;
    m_pipe1    = pin;
  endtask

  task automatic push_expect(input logic hand, input int ch,
                             input logic [W-1:0] e0, input logic [W-1:0] e1,
                             input logic eo0, input logic eo1);
    exp_t r;
    r.vec = vec_num;
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < CH; c++) begin
        r.acc[i][c*W +: W] = m_acc[i][c];
        r.byp[i][c*W +: W] = m_byp[i][c];
        r.ov[i][c]         = m_ov[i][c];
        r.val[i][c]        = m_val[i][c];
      end
    end
    r.pass[0] = m_pipe0[2];
    r.pass[1] = m_pipe1;
    r.hand    = hand;
    r.ch      = ch;
    r.hacc[0] = e0;
    r.hacc[1] = e1;
    r.hov[0]  = eo0;
    r.hov[1]  = eo1;
    sb.push_back(r);
    -> check_ev;
  endtask

  task automatic drive_inputs(input logic [CH-1:0] v, input logic [CH-1:0] cl,
                              input logic [CH-1:0] bp, input logic [CH*W-1:0] ain);
    logic [159:0] rnd;
    rnd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    cur_pass = rnd[PW-1:0];
    bus0.in_valid = v;  bus0.clear = cl;  bus0.accum_bypass = bp;
    bus0.accum_in = ain; bus0.pass_in = cur_pass;
    bus1.in_valid = v;  bus1.clear = cl;  bus1.accum_bypass = bp;
    bus1.accum_in = ain; bus1.pass_in = cur_pass;
  endtask

  // One clock of stimulus; optional hand-computed expectation for one channel.
  task automatic apply_stimulus(input logic [CH-1:0] v, input logic [CH-1:0] cl,
                                input logic [CH-1:0] bp, input logic [CH*W-1:0] ain,
                                input logic hand, input int ch,
                                input logic [W-1:0] e0, input logic [W-1:0] e1,
                                input logic eo0, input logic eo1);
    drive_inputs(v, cl, bp, ain);
    @(posedge clk);
    model_step(v, cl, bp, ain, cur_pass);
    vec_num++;
    push_expect(hand, ch, e0, e1, eo0, eo1);
    #2;
  endtask

  task automatic reset_midstream();
    #4;
    rst_n = 1'b0;
    model_reset();
    vec_num++;
    push_expect(1'b1, 1, 8'h00, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    vec_num++;
    push_expect(1'b1, 1, 8'h00, 8'h00, 1'b0, 1'b0);
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_output(input string name, input int vec,
                              input logic [PW-1:0] act, input logic [PW-1:0] exp_val);
    checks++;
    if (act !== exp_val) begin
      errors++;
      $display("[TB] FAIL %s vec %0d: got %h expected %h", name, vec, act, exp_val);
    end
  endtask

  // Monitor: compares registered outputs shortly after each queued edge.
  initial begin
    exp_t r;
    forever begin
      @(check_ev);
      #1;
      while (sb.size() > 0) begin
        r = sb.pop_front();
        check_output("wrap_accum_out",  r.vec, bus0.accum_out,        r.acc[0]);
        check_output("wrap_bypass_out", r.vec, bus0.accum_bypass_out, r.byp[0]);
        check_output("wrap_overflow",   r.vec, bus0.overflow,         r.ov[0]);
        check_output("wrap_out_valid",  r.vec, bus0.out_valid,        r.val[0]);
        check_output("wrap_pass_out",   r.vec, bus0.pass_out,         r.pass[0]);
        check_output("sat_accum_out",   r.vec, bus1.accum_out,        r.acc[1]);
        check_output("sat_bypass_out",  r.vec, bus1.accum_bypass_out, r.byp[1]);
        check_output("sat_overflow",    r.vec, bus1.overflow,         r.ov[1]);
        check_output("sat_out_valid",   r.vec, bus1.out_valid,        r.val[1]);
        check_output("sat_pass_out",    r.vec, bus1.pass_out,         r.pass[1]);
        if (r.hand) begin
          check_output("hand_wrap_acc", r.vec, bus0.accum_out[r.ch*W +: W], r.hacc[0]);
          check_output("hand_sat_acc",  r.vec, bus1.accum_out[r.ch*W +: W], r.hacc[1]);
          check_output("hand_wrap_ov",  r.vec, bus0.overflow[r.ch],         r.hov[0]);
          check_output("hand_sat_ov",   r.vec, bus1.overflow[r.ch],         r.hov[1]);
        end
      end
    end
  end

  initial begin
    logic [CH-1:0]   rv, rc, rb;
    logic [CH*W-1:0] ra;

    rst_n = 1'b0;
    drive_inputs('0, '0, '0, '0);
    model_reset();
    #1;
    push_expect(1'b1, 0, 8'h00, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    vec_num++;
    push_expect(1'b1, 1, 8'h00, 8'h00, 1'b0, 1'b0);
    #2;
    @(negedge clk);
    rst_n = 1'b1;

    // Accumulate on channel 1, then bypass a fresh addend.
    apply_stimulus(4'b0011, 4'b0000, 4'b0000, {8'd0, 8'd0, 8'd100, 8'd0}, 1'b1, 1, 8'd100, 8'd100, 1'b0, 1'b0);
    apply_stimulus(4'b0010, 4'b0000, 4'b0000, {8'd0, 8'd0, 8'd5,   8'd0}, 1'b1, 1, 8'd105, 8'd105, 1'b0, 1'b0);
    apply_stimulus(4'b0010, 4'b0000, 4'b0000, {8'd0, 8'd0, 8'd5,   8'd0}, 1'b1, 1, 8'd110, 8'd110, 1'b0, 1'b0);
    apply_stimulus(4'b0010, 4'b0000, 4'b0000, {8'd0, 8'd0, 8'd5,   8'd0}, 1'b1, 1, 8'd115, 8'd115, 1'b0, 1'b0);
    apply_stimulus(4'b0010, 4'b0000, 4'b0010, {8'd0, 8'd0, 8'd7,   8'd0}, 1'b1, 1, 8'd122, 8'd122, 1'b0, 1'b0);
    apply_stimulus(4'b0000, 4'b0000, 4'b0000, {8'd0, 8'd0, 8'd9,   8'd0}, 1'b1, 1, 8'd122, 8'd122, 1'b0, 1'b0);

    reset_midstream();

    // Overflow on channel 2: wrap bank wraps, saturate bank clamps.
    apply_stimulus(4'b0100, 4'b0000, 4'b0000, {8'h00, 8'hF0, 8'h00, 8'h00}, 1'b1, 2, 8'hF0, 8'hF0, 1'b0, 1'b0);
    apply_stimulus(4'b0100, 4'b0000, 4'b0000, {8'h00, 8'h20, 8'h00, 8'h00}, 1'b1, 2, 8'h10, 8'hFF, 1'b1, 1'b1);
    apply_stimulus(4'b0100, 4'b0000, 4'b0000, {8'h00, 8'h01, 8'h00, 8'h00}, 1'b1, 2, 8'h11, 8'hFF, 1'b1, 1'b1);
    apply_stimulus(4'b0100, 4'b0100, 4'b0000, {8'h00, 8'h55, 8'h00, 8'h00}, 1'b1, 2, 8'h00, 8'h00, 1'b0, 1'b0);

    // Mixed clear, add and bypass across channels in one cycle.
    apply_stimulus(4'b1010, 4'b0001, 4'b0100, {8'hC0, 8'h99, 8'h30, 8'h11}, 1'b1, 3, 8'hC0, 8'hC0, 1'b0, 1'b0);
    apply_stimulus(4'b1000, 4'b0000, 4'b0000, {8'h50, 8'h00, 8'h00, 8'h00}, 1'b1, 3, 8'h10, 8'hFF, 1'b1, 1'b1);
    apply_stimulus(4'b1001, 4'b0000, 4'b1000, {8'h05, 8'h00, 8'h00, 8'h03}, 1'b1, 0, 8'h03, 8'h03, 1'b0, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      rv = 4'($urandom_range(0, 15));
      rc = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      rb = 4'($urandom_range(0, 15));
      ra = $urandom();
      apply_stimulus(rv, rc, rb, ra, 1'b0, 0, 8'h00, 8'h00, 1'b0, 1'b0);
    end

    #10;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
